// File: rtl/soc_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : soc_mem_pkg                                                       |
// | Desc   : Shared memory-subsystem request/response types and decode helper. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package soc_mem_pkg;

    localparam int unsigned c_MEM_ADDR_WIDTH = 32;
    localparam int unsigned c_MEM_DATA_WIDTH = 32;
    localparam int unsigned c_MEM_BE_WIDTH   = c_MEM_DATA_WIDTH / 8;

    typedef struct packed {
        logic                        we;
        logic [c_MEM_BE_WIDTH-1:0]   be;
        logic [c_MEM_ADDR_WIDTH-1:0] addr;
        logic [c_MEM_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                        rvalid;
        logic                        err;
        logic [c_MEM_DATA_WIDTH-1:0] rdata;
    } mem_rsp_t;

    // Evaluated in 64 bits so base + 4*words cannot wrap for 32-bit maps.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] words);
        return (addr >= base) && (addr < (base + (words << 2)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                        |
// | Desc   : Combinational round-robin picker: first request at/after pointer. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int unsigned c_IDX_W = $clog2(N);

    int   w_j;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int o = 0; o < int'(N); o++) begin
            w_j = int'(i_ptr) + o;
            if (w_j >= int'(N)) begin
                w_j = w_j - int'(N);
            end
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = c_IDX_W'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sp_ram_arbiter                                                    |
// | Desc   : Round-robin sharing of one single-port SRAM among OBI masters.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module sp_ram_arbiter #(
    parameter int unsigned           N_REQ      = 2,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MEM_WORDS  = 1024
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [N_REQ-1:0]                        req_i,
    input  logic [N_REQ-1:0]                        we_i,
    input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]      be_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]        wdata_i,
    output logic [N_REQ-1:0]                        gnt_o,
    output logic [N_REQ-1:0]                        rvalid_o,
    output logic [N_REQ-1:0]                        err_o,
    output logic [N_REQ-1:0][DATA_WIDTH-1:0]        rdata_o,
    output logic                                    ram_en_o,
    output logic                                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0]                 ram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0]            ram_addr_o,
    output logic [DATA_WIDTH-1:0]                   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]                   ram_rdata_i
);

    import soc_mem_pkg::*;

    localparam int unsigned c_IDX_W  = $clog2(N_REQ);
    localparam int unsigned c_RAM_AW = $clog2(MEM_WORDS);
    localparam int unsigned c_BE_W   = DATA_WIDTH / 8;

    logic [N_REQ-1:0]      w_req;
    logic [N_REQ-1:0]      w_gnt;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_any;
    logic                  w_in_range;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_unused_off;

    logic [c_IDX_W-1:0]    r_ptr;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rsp_we;
    logic [c_IDX_W-1:0]    r_rsp_idx;
    logic                  r_ram_we;
    logic [c_BE_W-1:0]     r_ram_be;
    logic [c_RAM_AW-1:0]   r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;

    // Requests are masked while in reset so no grant escapes.
    assign w_req = rst_ni ? req_i : '0;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_any        = |w_req;
    assign w_in_range   = addr_in_range(64'(addr_i[w_idx]), 64'(BASE_ADDR), 64'(MEM_WORDS));
    assign w_hit        = w_any & w_in_range;
    assign w_off        = addr_i[w_idx] - BASE_ADDR;
    assign w_unused_off = ^w_off;

    assign gnt_o       = w_gnt;
    assign ram_en_o    = w_hit;
    assign ram_we_o    = w_hit ? we_i[w_idx]              : r_ram_we;
    assign ram_be_o    = w_hit ? be_i[w_idx]              : r_ram_be;
    assign ram_addr_o  = w_hit ? w_off[c_RAM_AW+1:2]      : r_ram_addr;
    assign ram_wdata_o = w_hit ? wdata_i[w_idx]           : r_ram_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_idx   <= '0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_rsp_valid <= w_any;
            r_rsp_err   <= w_any & ~w_in_range;
            r_rsp_we    <= we_i[w_idx];
            r_rsp_idx   <= w_idx;
            if (w_any) begin
                r_ptr <= (w_idx == c_IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
            // Hold the last in-range access so idle cycles do not toggle the RAM bus.
            if (w_hit) begin
                r_ram_we    <= ram_we_o;
                r_ram_be    <= ram_be_o;
                r_ram_addr  <= ram_addr_o;
                r_ram_wdata <= ram_wdata_o;
            end
        end
    end

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_rsp
        assign rvalid_o[i] = r_rsp_valid && (r_rsp_idx == c_IDX_W'(i));
        assign err_o[i]    = rvalid_o[i] & r_rsp_err;
        assign rdata_o[i]  = (rvalid_o[i] && !r_rsp_err && !r_rsp_we) ? ram_rdata_i : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sp_ram_arbiter                                                 |
// | Desc   : Scoreboard bench for sp_ram_arbiter with a behavioural SRAM.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_sp_ram_arbiter;

    localparam int N     = 2;
    localparam int WORDS = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]           req, we;
    logic [N-1:0][3:0]      be;
    logic [N-1:0][31:0]     addr, wdata;
    logic [N-1:0]           gnt, rvalid, err;
    logic [N-1:0][31:0]     rdata;
    logic                   ram_en, ram_we;
    logic [3:0]             ram_be;
    logic [9:0]             ram_addr;
    logic [31:0]            ram_wdata, ram_rdata;

    sp_ram_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .MEM_WORDS(WORDS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .err_o(err), .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEAD_BEEF;
        if (i == 2) return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] ram [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++) ram[i] = init_word(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we)
                    for (int b = 0; b < 4; b++)
                        if (ram_be[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] sb_mem [WORDS];
    int          m_ptr;
    int          wait_cnt [N];
    int          last_k;
    logic        last_valid;
    logic        last_we;
    logic [3:0]  last_be;
    logic [9:0]  last_addr;
    logic [31:0] last_wdata;
    logic [N-1:0] obs_gnt;
    logic [31:0]  obs_rdata;
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            int j;
            j = (p + o) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic set_req(input int m, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d);
        req[m] = 1'b1; we[m] = w; be[m] = b; addr[m] = a; wdata[m] = d;
    endtask

    // Called just after a falling edge with inputs set; ends on the rising edge.
    task automatic grant_phase();
        int          k;
        logic        inr;
        int          w;
        exp_t        e;
        logic [N-1:0] exp_gnt;
        #1;
        obs_gnt = gnt;
        k = model_pick(req, m_ptr);
        exp_gnt = '0;
        if (k >= 0) exp_gnt[k] = 1'b1;
        check_val("gnt", gnt, exp_gnt);
        for (int m = 0; m < N; m++)
            if (req[m] && !exp_gnt[m]) wait_cnt[m]++;
        last_k = k;
        if (k >= 0) begin
            check_val("wait_bound", wait_cnt[k] < N, 1);
            wait_cnt[k] = 0;
            inr = (64'(addr[k]) >= 64'(BASE)) && (64'(addr[k]) < 64'(BASE) + 64'(4 * WORDS));
            check_val("ram_en", ram_en, inr);
            e.idx = k;
            if (inr) begin
                w = int'((addr[k] - BASE) >> 2);
                check_val("ram_addr", ram_addr, w);
                check_val("ram_we", ram_we, we[k]);
                e.err = 1'b0;
                e.rdata = we[k] ? 32'h0 : sb_mem[w];
                if (we[k]) begin
                    check_val("ram_be", ram_be, be[k]);
                    check_val("ram_wdata", ram_wdata, wdata[k]);
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) sb_mem[w][b*8 +: 8] = wdata[k][b*8 +: 8];
                end
                last_valid = 1'b1; last_we = we[k]; last_be = be[k];
                last_addr = 10'(w); last_wdata = wdata[k];
            end else begin
                e.err = 1'b1;
                e.rdata = 32'h0;
                last_valid = 1'b0;
            end
            sb_q.push_back(e);
            m_ptr = (k + 1) % N;
        end else begin
            check_val("ram_en_idle", ram_en, 0);
            if (last_valid) begin
                check_val("hold_addr", ram_addr, last_addr);
                check_val("hold_we", ram_we, last_we);
                check_val("hold_be", ram_be, last_be);
                check_val("hold_wdata", ram_wdata, last_wdata);
            end
        end
        @(posedge clk);
    endtask

    task automatic resp_phase();
        exp_t e;
        logic [N-1:0] ev, ee;
        @(negedge clk);
        obs_rdata = '0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ev = '0; ee = '0;
            ev[e.idx] = 1'b1;
            ee[e.idx] = e.err;
            obs_rdata = rdata[e.idx];
            check_val("rvalid", rvalid, ev);
            check_val("err", err, ee);
            check_val("rdata", rdata[e.idx], e.rdata);
            for (int m = 0; m < N; m++)
                if (m != e.idx) check_val("rdata_other", rdata[m], 0);
        end else begin
            check_val("rvalid_idle", rvalid, 0);
        end
        if (last_k >= 0) req[last_k] = 1'b0;
    endtask

    task automatic step();
        grant_phase();
        resp_phase();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        sb_q.delete();
        m_ptr = 0;
        last_valid = 1'b0;
        for (int m = 0; m < N; m++) wait_cnt[m] = 0;
        @(negedge clk);
        check_val("rst_gnt", gnt, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_err", err, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_ram_en", ram_en, 0);
        check_val("rst_ram_we", ram_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] cont_exp [4];

    initial begin
        cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < WORDS; i++) sb_mem[i] = init_word(i);
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        last_k = -1;
        @(negedge clk);
        do_reset();

        // Single read of word 5
        set_req(0, 1'b0, 4'hF, 32'h14, 32'h0);
        grant_phase();
        check_val("single_gnt", obs_gnt, 2'b01);
        resp_phase();
        check_val("single_rdata", obs_rdata, 32'hDEAD_BEEF);

        // Contention from reset
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b0, 4'hF, 32'h14, 32'h0);
            set_req(1, 1'b0, 4'hF, 32'h08, 32'h0);
            grant_phase();
            check_val("cont_seq", obs_gnt, cont_exp[c]);
            resp_phase();
        end
        req = '0;

        // Byte write then read-back
        set_req(1, 1'b1, 4'b0010, 32'h8, 32'h0000_AB00);
        step();
        set_req(1, 1'b0, 4'hF, 32'h8, 32'h0);
        step();
        check_val("byte_rmw", obs_rdata, 32'h1122_AB44);

        // Out of range, and a misaligned in-range read
        set_req(0, 1'b0, 4'hF, 32'h1000, 32'h0);
        grant_phase();
        check_val("oor_en", ram_en, 0);
        resp_phase();
        set_req(0, 1'b0, 4'hF, 32'h17, 32'h0);
        step();
        check_val("misalign", obs_rdata, 32'hDEAD_BEEF);

        // Reset in the cycle right after a grant
        set_req(0, 1'b0, 4'hF, 32'h14, 32'h0);
        grant_phase();
        #2 rst_n = 1'b0;
        req = '0;
        sb_q.delete();
        m_ptr = 0;
        last_valid = 1'b0;
        for (int m = 0; m < N; m++) wait_cnt[m] = 0;
        @(negedge clk);
        check_val("midrst_rvalid", rvalid, 0);
        @(negedge clk);
        check_val("midrst_rvalid2", rvalid, 0);
        rst_n = 1'b1;
        set_req(0, 1'b0, 4'hF, 32'h14, 32'h0);
        set_req(1, 1'b0, 4'hF, 32'h08, 32'h0);
        grant_phase();
        check_val("midrst_tie", obs_gnt, 2'b01);
        resp_phase();
        step();
        req = '0;
        step();

        // Random soak
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int m = 0; m < N; m++) begin
                if (!req[m] && ($urandom_range(3, 0) != 0)) begin
                    logic [31:0] a;
                    if ($urandom_range(9, 0) == 0)
                        a = 32'h1000 + 32'($urandom_range(255, 0)) * 4;
                    else
                        a = 32'($urandom_range(63, 0)) * 4 + 32'($urandom_range(3, 0));
                    set_req(m, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 1)), a, $urandom);
                end
            end
            step();
        end
        req = '0;
        step();
        step();
        check_val("drain", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
